// File: rtl/rs_issue_scheduler.sv
// rs_issue_scheduler
//   Issue scheduler for one reservation station of DEPTH entries. It tracks
//   per-entry busy/ready bits and hands the lowest free index to dispatch.
//   CDB wakeups mark entries ready. One ready entry per cycle is picked
//   round-robin into a registered issue slot, which is drained over a
//   valid/ready handshake.
//
//   Optional build macro: RS_WAKE_BYPASS_EN
//     When defined, a same-cycle wakeup also counts as a candidate for
//     selection, so a woken entry can issue one cycle earlier.
//
// Ports
//   clk_i, rst_i      clock, asynchronous active-high reset
//   flush_i           synchronous squash of every entry
//   alloc_valid_i     dispatch requests an entry
//   alloc_ready_o     at least one entry is free
//   alloc_idx_o       lowest free entry index
//   wake_valid_i      CDB wakeup strobe
//   wake_idx_i        entry to wake
//   issue_valid_o     issue slot holds a selected entry
//   issue_ready_i     functional unit accepts the issue
//   issue_idx_o       selected entry index
//   issue_onehot_o    one-hot of issue_idx_o (zero when slot empty)
//   busy_o            per-entry busy bits
//   occupancy_o       popcount of busy_o
module rs_issue_scheduler #(
   parameter int WIDTH = 3,
   parameter int DEPTH = (1 << WIDTH)
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               flush_i,
   input  logic               alloc_valid_i,
   output logic               alloc_ready_o,
   output logic [WIDTH-1:0]   alloc_idx_o,
   input  logic               wake_valid_i,
   input  logic [WIDTH-1:0]   wake_idx_i,
   output logic               issue_valid_o,
   input  logic               issue_ready_i,
   output logic [WIDTH-1:0]   issue_idx_o,
   output logic [DEPTH-1:0]   issue_onehot_o,
   output logic [DEPTH-1:0]   busy_o,
   output logic [WIDTH:0]     occupancy_o
);

   localparam int OW = WIDTH + 1;

   logic [DEPTH-1:0] busy;
   logic [DEPTH-1:0] rdy;
   logic [WIDTH-1:0] rr_ptr;

   logic             alloc_fire;
   logic             issue_fire;
   logic             slot_free;
   logic             wake_hit;
   logic [DEPTH-1:0] cand;
   logic             sel_found;
   logic [WIDTH-1:0] sel_idx;

   // Lowest-indexed free entry: scan downward so the last hit is the lowest.
   always_comb begin
      alloc_ready_o = |(~busy);
      alloc_idx_o   = '0;
      for (int i = DEPTH - 1; i >= 0; i--)
         if (!busy[i]) alloc_idx_o = WIDTH'(i);
   end

   assign alloc_fire = alloc_valid_i & alloc_ready_o;
   assign issue_fire = issue_valid_o & issue_ready_i;
   assign slot_free  = ~issue_valid_o | issue_ready_i;

   // A wakeup only counts for an allocated entry that is not already sitting
   // in the issue slot; otherwise the slot entry could be granted twice.
   assign wake_hit = wake_valid_i & busy[wake_idx_i] &
                     ~(issue_valid_o && (issue_idx_o == wake_idx_i));

   always_comb begin
      cand = busy & rdy;
`ifdef RS_WAKE_BYPASS_EN
      if (wake_hit) cand[wake_idx_i] = 1'b1;
`endif
   end

   // Round-robin search starting one past the last grant. The WIDTH-bit
   // probe index wraps naturally because DEPTH == 1<<WIDTH; the final probe
   // lands back on rr_ptr itself.
   always_comb begin
      logic [WIDTH-1:0] probe;
      sel_found = 1'b0;
      sel_idx   = '0;
      probe     = '0;
      for (int i = 0; i < DEPTH; i++) begin
         probe = rr_ptr + WIDTH'(i + 1);
         if (!sel_found && cand[probe]) begin
            sel_found = 1'b1;
            sel_idx   = probe;
         end
      end
   end

   always_comb begin
      issue_onehot_o = '0;
      if (issue_valid_o) issue_onehot_o[issue_idx_o] = 1'b1;
   end

   always_comb begin
      logic [WIDTH:0] cnt;
      cnt = '0;
      for (int i = 0; i < DEPTH; i++) cnt = cnt + OW'(busy[i]);
      occupancy_o = cnt;
   end

   assign busy_o = busy;

   // Update order matters where bits may coincide: a winner's rdy clear must
   // beat a same-cycle wake of that entry (bypass-granted entries never keep
   // rdy). Alloc never hits the fired entry because that entry is still busy.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         busy          <= '0;
         rdy           <= '0;
         rr_ptr        <= WIDTH'(DEPTH - 1);
         issue_valid_o <= 1'b0;
         issue_idx_o   <= '0;
      end else if (flush_i) begin
         busy          <= '0;
         rdy           <= '0;
         rr_ptr        <= WIDTH'(DEPTH - 1);
         issue_valid_o <= 1'b0;
         issue_idx_o   <= '0;
      end else begin
         if (issue_fire) busy[issue_idx_o] <= 1'b0;
         if (alloc_fire) begin
            busy[alloc_idx_o] <= 1'b1;
            rdy[alloc_idx_o]  <= 1'b0;
         end
         if (wake_hit) rdy[wake_idx_i] <= 1'b1;
         if (slot_free) begin
            if (sel_found) begin
               issue_valid_o <= 1'b1;
               issue_idx_o   <= sel_idx;
               rdy[sel_idx]  <= 1'b0;
               rr_ptr        <= sel_idx;
            end else begin
               issue_valid_o <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_rs_issue_scheduler.sv
module tb_rs_issue_scheduler;

   localparam int W = 3;
   localparam int D = 8;

   logic           clk_i = 1'b0;
   logic           rst_i;
   logic           flush_i;
   logic           alloc_valid_i;
   logic           alloc_ready_o;
   logic [W-1:0]   alloc_idx_o;
   logic           wake_valid_i;
   logic [W-1:0]   wake_idx_i;
   logic           issue_valid_o;
   logic           issue_ready_i;
   logic [W-1:0]   issue_idx_o;
   logic [D-1:0]   issue_onehot_o;
   logic [D-1:0]   busy_o;
   logic [W:0]     occupancy_o;

   rs_issue_scheduler #(.WIDTH(W), .DEPTH(D)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
      .alloc_valid_i(alloc_valid_i), .alloc_ready_o(alloc_ready_o),
      .alloc_idx_o(alloc_idx_o), .wake_valid_i(wake_valid_i),
      .wake_idx_i(wake_idx_i), .issue_valid_o(issue_valid_o),
      .issue_ready_i(issue_ready_i), .issue_idx_o(issue_idx_o),
      .issue_onehot_o(issue_onehot_o), .busy_o(busy_o),
      .occupancy_o(occupancy_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      bit       aready;
      int       aidx;
      bit       ivalid;
      int       iidx;
      int       onehot;
      int       busy;
      int       occ;
   } exp_t;

   exp_t q[$];
   int   total = 0;
   int   bad   = 0;

   // Reference model: plain arrays of entry state
   bit m_busy[D];
   bit m_rdy[D];
   bit m_sv;
   int m_si;
   int m_rr;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic void m_reset();
      for (int i = 0; i < D; i++) begin m_busy[i] = 0; m_rdy[i] = 0; end
      m_sv = 0; m_si = 0; m_rr = D - 1;
   endfunction

   function automatic exp_t m_view();
      exp_t e;
      e.aready = 0; e.aidx = 0; e.busy = 0; e.occ = 0;
      for (int i = D - 1; i >= 0; i--)
         if (!m_busy[i]) begin e.aready = 1; e.aidx = i; end
      for (int i = 0; i < D; i++)
         if (m_busy[i]) begin e.busy += (1 << i); e.occ++; end
      e.ivalid = m_sv;
      e.iidx   = m_si;
      e.onehot = m_sv ? (1 << m_si) : 0;
      return e;
   endfunction

   // One clock edge of the spec's rules, using the inputs held during the cycle.
   function automatic void m_step(bit fl, bit av, bit wv, int wi, bit ir);
      bit nb[D]; bit nr[D]; bit candv[D];
      int fidx; bit has_free; bit wake_ok; bit found; int win;
      if (fl) begin m_reset(); return; end
      has_free = 0; fidx = 0;
      for (int i = D - 1; i >= 0; i--) if (!m_busy[i]) begin has_free = 1; fidx = i; end
      wake_ok = wv && m_busy[wi] && !(m_sv && m_si == wi);
      for (int i = 0; i < D; i++) candv[i] = m_busy[i] && m_rdy[i];
`ifdef RS_WAKE_BYPASS_EN
      if (wake_ok) candv[wi] = 1;
`endif
      found = 0; win = 0;
      for (int k = 1; k <= D; k++)
         if (!found && candv[(m_rr + k) % D]) begin found = 1; win = (m_rr + k) % D; end
      nb = m_busy; nr = m_rdy;
      if (m_sv && ir) nb[m_si] = 0;
      if (av && has_free) begin nb[fidx] = 1; nr[fidx] = 0; end
      if (wake_ok) nr[wi] = 1;
      if (!m_sv || ir) begin
         if (found) begin m_sv = 1; m_si = win; nr[win] = 0; m_rr = win; end
         else m_sv = 0;
      end
      m_busy = nb; m_rdy = nr;
   endfunction

   // Monitor: DUT state after each edge is compared at the following negedge
   initial begin
      exp_t e;
      forever begin
         @(negedge clk_i);
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("alloc_ready", int'(alloc_ready_o), int'(e.aready));
            if (e.aready) chk("alloc_idx", int'(alloc_idx_o), e.aidx);
            chk("issue_valid", int'(issue_valid_o), int'(e.ivalid));
            if (e.ivalid) chk("issue_idx", int'(issue_idx_o), e.iidx);
            chk("issue_onehot", int'(issue_onehot_o), e.onehot);
            chk("busy", int'(busy_o), e.busy);
            chk("occupancy", int'(occupancy_o), e.occ);
         end
      end
   end

   // Stimulus phases: {alloc%, wake%, ready%, flush%}
   int ph[6][4] = '{'{95, 0, 0, 0}, '{90, 30, 80, 1}, '{90, 70, 100, 0},
                    '{20, 70, 30, 2}, '{80, 60, 0, 0}, '{50, 50, 50, 3}};

   initial begin
      rst_i = 1; flush_i = 0; alloc_valid_i = 0; wake_valid_i = 0;
      wake_idx_i = '0; issue_ready_i = 0;
      m_reset();
      repeat (3) begin
         @(posedge clk_i);
         q.push_back(m_view());
      end
      #1 rst_i = 0;
      for (int p = 0; p < 6; p++) begin
         for (int c = 0; c < 300; c++) begin
            @(posedge clk_i);
            m_step(flush_i, alloc_valid_i, wake_valid_i, int'(wake_idx_i), issue_ready_i);
            q.push_back(m_view());
            #1;
            alloc_valid_i = ($urandom_range(99) < ph[p][0]);
            wake_valid_i  = ($urandom_range(99) < ph[p][1]);
            wake_idx_i    = W'($urandom_range(D - 1));
            issue_ready_i = ($urandom_range(99) < ph[p][2]);
            flush_i       = ($urandom_range(99) < ph[p][3]);
         end
      end
      @(posedge clk_i);
      m_step(flush_i, alloc_valid_i, wake_valid_i, int'(wake_idx_i), issue_ready_i);
      q.push_back(m_view());
      #1 flush_i = 0; alloc_valid_i = 0; wake_valid_i = 0; issue_ready_i = 0;
      repeat (3) @(posedge clk_i);
      total++;
      if (q.size() != 0) begin
         bad++;
         $display("FAIL drain actual=%0d expected=0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
